// File: rtl/ctrl_troco_if.sv
// ctrl_troco_if: coin/refund/dispense signal bundle for the change controller.
//   master : drives coin pulses, cancel and ack; observes the controller outputs
//   slave  : the controller side (ctrl_troco)
//   i_moeda_25/50/1 : single-cycle coin pulses worth 1/2/4 credit units
//   i_cancel        : single-cycle refund request
//   i_ack           : completion strobe from dispense/eject mechanism
//   o_credit        : current credit (25-cent units)
//   o_vend          : dispense request level, held until i_ack
//   o_eject_50/25   : change-coin eject level, held until i_ack
//   o_reject        : one-cycle pulse, inserted coin(s) returned
//   o_busy          : controller not idle
interface ctrl_troco_if;
  logic       i_moeda_25;
  logic       i_moeda_50;
  logic       i_moeda_1;
  logic       i_cancel;
  logic       i_ack;
  logic [3:0] o_credit;
  logic       o_vend;
  logic       o_eject_50;
  logic       o_eject_25;
  logic       o_reject;
  logic       o_busy;

  modport master (
    output i_moeda_25, i_moeda_50, i_moeda_1, i_cancel, i_ack,
    input  o_credit, o_vend, o_eject_50, o_eject_25, o_reject, o_busy
  );

  modport slave (
    input  i_moeda_25, i_moeda_50, i_moeda_1, i_cancel, i_ack,
    output o_credit, o_vend, o_eject_50, o_eject_25, o_reject, o_busy
  );
endinterface

// File: rtl/ctrl_troco.sv
// ctrl_troco: vending credit / change controller.
//   Accepts 25c, 50c and 1-real coins, vends once credit reaches PRICE and
//   pays the remainder (or a full refund on cancel) one change coin at a time.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus    : ctrl_troco_if.slave (coin pulses, cancel, ack in; credit, vend,
//            eject, reject, busy out; all outputs registered)
//
// state  | meaning
// IDLE   | accepting coins, waiting for credit >= PRICE or cancel
// VEND   | o_vend held until the mechanism acks
// CHANGE | one change coin eject held until ack
// GAP    | one dead cycle between change coins
module ctrl_troco #(
  parameter int PRICE      = 4,
  parameter int MAX_CREDIT = 8
) (
  input logic          i_clk,
  input logic          i_rst,
  ctrl_troco_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE, GAP} state_t;

  localparam logic [3:0] PRICE_U = 4'(PRICE);
  localparam logic [4:0] MAX_U   = 5'(MAX_CREDIT);

  state_t     state;
  logic [3:0] credit;
  logic       vend;
  logic       eject_50;
  logic       eject_25;
  logic       reject;
  logic       busy;

  logic [2:0] coin_sum;
  logic       coin_any;
  logic [4:0] credit_plus;
  logic       coin_fits;
  logic [3:0] credit_coin;
  logic [3:0] remainder;

  // Coin weights are 1/2/4, so the pulses concatenated are already their sum.
  always_comb begin
    coin_sum    = {bus.i_moeda_1, bus.i_moeda_50, bus.i_moeda_25};
    coin_any    = |coin_sum;
    credit_plus = {1'b0, credit} + {2'b00, coin_sum};
    coin_fits   = (credit_plus <= MAX_U);
    credit_coin = coin_fits ? credit_plus[3:0] : credit;
    remainder   = credit - PRICE_U;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      credit   <= 4'd0;
      vend     <= 1'b0;
      eject_50 <= 1'b0;
      eject_25 <= 1'b0;
      reject   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // Coins are refused outside IDLE, or when they would exceed the ceiling.
      reject <= coin_any && ((state != IDLE) || !coin_fits);
      case (state)
        IDLE: begin
          credit <= credit_coin;
          // Cancel beats a vend triggered in the same cycle.
          if (bus.i_cancel && (credit_coin != 4'd0)) begin
            state    <= CHANGE;
            busy     <= 1'b1;
            eject_50 <= (credit_coin >= 4'd2);
            eject_25 <= (credit_coin == 4'd1);
          end else if (credit >= PRICE_U) begin
            state <= VEND;
            vend  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        VEND: begin
          if (bus.i_ack) begin
            credit <= remainder;
            vend   <= 1'b0;
            if (remainder != 4'd0) begin
              state    <= CHANGE;
              eject_50 <= (remainder >= 4'd2);
              eject_25 <= (remainder == 4'd1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        CHANGE: begin
          if (bus.i_ack) begin
            // eject_50 is only raised with credit >= 2, so no underflow.
            credit   <= eject_50 ? (credit - 4'd2) : (credit - 4'd1);
            eject_50 <= 1'b0;
            eject_25 <= 1'b0;
            state    <= GAP;
          end
        end
        GAP: begin
          if (credit != 4'd0) begin
            state    <= CHANGE;
            eject_50 <= (credit >= 4'd2);
            eject_25 <= (credit == 4'd1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_credit   = credit;
  assign bus.o_vend     = vend;
  assign bus.o_eject_50 = eject_50;
  assign bus.o_eject_25 = eject_25;
  assign bus.o_reject   = reject;
  assign bus.o_busy     = busy;

endmodule

// File: tb/tb_ctrl_troco.sv
// tb_ctrl_troco: directed stimulus with a scoreboard of expected output events
// (reject pulse, vend rise, eject rises, each tagged with the credit shown at
// that moment) checked by an independent monitor, plus direct credit/state checks.
module tb_ctrl_troco;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ctrl_troco_if bus_if ();

  ctrl_troco #(.PRICE(4), .MAX_CREDIT(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  typedef struct {
    int kind;
    int credit;
  } ev_t;

  localparam int K_REJ  = 0;
  localparam int K_VEND = 1;
  localparam int K_E50  = 2;
  localparam int K_E25  = 3;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic void expect_ev(input int k, input int c);
    ev_t e;
    e.kind   = k;
    e.credit = c;
    exp_q.push_back(e);
  endfunction

  task automatic check_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic observe(input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual_kind=%0d required=none at %0t", k, $time);
    end else begin
      e = exp_q.pop_front();
      check_eq("event_kind", k, e.kind);
      check_eq("event_credit", int'(bus_if.o_credit), e.credit);
    end
  endtask

  // Monitor: samples on the falling edge, independent of the stimulus.
  logic vend_d = 1'b0;
  logic e50_d  = 1'b0;
  logic e25_d  = 1'b0;

  always @(negedge clk) begin
    if (bus_if.o_reject === 1'b1)                  observe(K_REJ);
    if (bus_if.o_vend === 1'b1 && !vend_d)         observe(K_VEND);
    if (bus_if.o_eject_50 === 1'b1 && !e50_d)      observe(K_E50);
    if (bus_if.o_eject_25 === 1'b1 && !e25_d)      observe(K_E25);
    vend_d = (bus_if.o_vend === 1'b1);
    e50_d  = (bus_if.o_eject_50 === 1'b1);
    e25_d  = (bus_if.o_eject_25 === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c25, input logic c50, input logic c1,
                       input logic cancel, input logic ack);
    bus_if.i_moeda_25 = c25;
    bus_if.i_moeda_50 = c50;
    bus_if.i_moeda_1  = c1;
    bus_if.i_cancel   = cancel;
    bus_if.i_ack      = ack;
    tick();
    bus_if.i_moeda_25 = 1'b0;
    bus_if.i_moeda_50 = 1'b0;
    bus_if.i_moeda_1  = 1'b0;
    bus_if.i_cancel   = 1'b0;
    bus_if.i_ack      = 1'b0;
  endtask

  // Wait (bounded) for a vend/eject request, then acknowledge it.
  task automatic do_ack(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.o_vend || bus_if.o_eject_50 || bus_if.o_eject_25) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout actual=no_request required=request", name);
    end
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic check_idle(input string name, input int credit);
    check_eq({name, "_credit"}, int'(bus_if.o_credit), credit);
    check_eq({name, "_busy"}, int'(bus_if.o_busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.i_moeda_25 = 1'b0;
    bus_if.i_moeda_50 = 1'b0;
    bus_if.i_moeda_1  = 1'b0;
    bus_if.i_cancel   = 1'b0;
    bus_if.i_ack      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset", 0);
    check_eq("reset_vend", int'(bus_if.o_vend), 0);
    check_eq("reset_e50", int'(bus_if.o_eject_50), 0);
    check_eq("reset_e25", int'(bus_if.o_eject_25), 0);
    check_eq("reset_reject", int'(bus_if.o_reject), 0);

    // 25, 25, 50 -> 1, 2, 4 then vend, ack -> 0 with no change
    expect_ev(K_VEND, 4);
    drive(1, 0, 0, 0, 0);
    check_eq("c25_a", int'(bus_if.o_credit), 1);
    drive(1, 0, 0, 0, 0);
    check_eq("c25_b", int'(bus_if.o_credit), 2);
    drive(0, 1, 0, 0, 0);
    check_eq("c50", int'(bus_if.o_credit), 4);
    do_ack("vend_exact");
    check_idle("vend_exact_done", 0);
    check_eq("vend_exact_drop", int'(bus_if.o_vend), 0);

    // 1 real then 50 -> 6, vend, change one 50
    expect_ev(K_VEND, 6);
    expect_ev(K_E50, 2);
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    check_eq("credit6", int'(bus_if.o_credit), 6);
    check_eq("vend6", int'(bus_if.o_vend), 1);
    do_ack("vend6");
    check_eq("e50_after_vend", int'(bus_if.o_eject_50), 1);
    do_ack("e50_6");
    check_eq("gap6_busy", int'(bus_if.o_busy), 1);
    check_eq("gap6_e50", int'(bus_if.o_eject_50), 0);
    tick();
    check_idle("vend6_done", 0);

    // Credit exactly at ceiling (8) is accepted
    expect_ev(K_VEND, 8);
    expect_ev(K_E50, 4);
    expect_ev(K_E50, 2);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    check_eq("credit8", int'(bus_if.o_credit), 8);
    do_ack("vend8");
    do_ack("e50_8a");
    do_ack("e50_8b");
    tick();
    check_idle("vend8_done", 0);

    // Simultaneous 25+50 -> 3, cancel -> 50 then 25
    expect_ev(K_E50, 3);
    expect_ev(K_E25, 1);
    drive(1, 1, 0, 0, 0);
    check_eq("simul_credit3", int'(bus_if.o_credit), 3);
    tick();
    check_idle("hold3", 3);
    drive(0, 0, 0, 1, 0);
    do_ack("refund3_e50");
    check_eq("gap3_e50", int'(bus_if.o_eject_50), 0);
    check_eq("gap3_e25", int'(bus_if.o_eject_25), 0);
    check_eq("gap3_credit", int'(bus_if.o_credit), 1);
    do_ack("refund3_e25");
    tick();
    check_idle("refund3_done", 0);

    // Credit 7, 1 real overflows -> reject; coin during VEND -> reject
    expect_ev(K_REJ, 7);
    expect_ev(K_VEND, 7);
    expect_ev(K_REJ, 7);
    expect_ev(K_E50, 3);
    expect_ev(K_E25, 1);
    drive(1, 1, 1, 0, 0);
    check_eq("credit7", int'(bus_if.o_credit), 7);
    drive(0, 0, 1, 0, 0);
    check_eq("overflow_credit", int'(bus_if.o_credit), 7);
    drive(1, 0, 0, 0, 0);
    check_eq("vend_coin_credit", int'(bus_if.o_credit), 7);
    check_eq("vend_coin_vend", int'(bus_if.o_vend), 1);
    do_ack("vend7");
    do_ack("e50_7");
    do_ack("e25_7");
    tick();
    check_idle("vend7_done", 0);

    // 25 at credit 1 with cancel -> credit 2, one 50 eject
    expect_ev(K_E50, 2);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    check_eq("coin_cancel_credit", int'(bus_if.o_credit), 2);
    do_ack("coin_cancel_e50");
    tick();
    check_idle("coin_cancel_done", 0);

    // Cancel at 0 and ack in IDLE ignored
    drive(0, 0, 0, 1, 0);
    check_idle("cancel_zero", 0);
    drive(0, 0, 0, 0, 1);
    check_idle("ack_idle", 0);

    // Coin crossing PRICE with cancel: refund wins
    expect_ev(K_E50, 4);
    expect_ev(K_E50, 2);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0);
    check_eq("cross_cancel_vend", int'(bus_if.o_vend), 0);
    check_eq("cross_cancel_e50", int'(bus_if.o_eject_50), 1);
    check_eq("cross_cancel_credit", int'(bus_if.o_credit), 4);
    do_ack("cross_e50a");
    do_ack("cross_e50b");
    tick();
    check_idle("cross_done", 0);

    // Reset while eject held, then ack ignored
    expect_ev(K_E50, 2);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    check_eq("pre_rst_e50", int'(bus_if.o_eject_50), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_rst", 0);
    check_eq("mid_rst_e50", int'(bus_if.o_eject_50), 0);
    drive(0, 0, 0, 0, 1);
    check_idle("post_rst_ack", 0);
    check_eq("post_rst_e50", int'(bus_if.o_eject_50), 0);

    // Reset overrides a coin in the same cycle
    rst = 1'b1;
    bus_if.i_moeda_50 = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.i_moeda_50 = 1'b0;
    check_idle("rst_coin", 0);
    check_eq("rst_coin_reject", int'(bus_if.o_reject), 0);

    repeat (3) tick();
    check_eq("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_troco.md
CTRL_TROCO -- requirements
Module: ctrl_troco

Interface
REQ-001 SHALL have parameter PRICE, default 4, meaning product price in 25-cent units (1..MAX_CREDIT).
REQ-002 SHALL have parameter MAX_CREDIT, default 8, meaning credit ceiling in 25-cent units (<=15).
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_moeda_25 / i_moeda_50 / i_moeda_1  input  1 each  debounced single-cycle coin pulses worth 1 / 2 / 4 units.
REQ-006 SHALL have port i_cancel  input  1  single-cycle refund request.
REQ-007 SHALL have port i_ack  input  1  completion strobe from the dispense/eject mechanism.
REQ-008 SHALL have port o_credit  output  4  current credit in 25-cent units.
REQ-009 SHALL have port o_vend  output  1  dispense request, level, held until i_ack.
REQ-010 SHALL have ports o_eject_50 / o_eject_25  output  1 each  change-coin eject request, level, held until i_ack.
REQ-011 SHALL have port o_reject  output  1  one-cycle pulse: inserted coin(s) returned.
REQ-012 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-013 All outputs SHALL be registered.

Function
REQ-014 FSM states SHALL be IDLE, VEND, CHANGE, GAP.
REQ-015 In IDLE, the coin sum of the cycle (all simultaneous pulses added) SHALL be added to credit if credit+sum <= MAX_CREDIT; otherwise credit unchanged and o_reject pulses the next cycle.
REQ-016 In IDLE, once credit >= PRICE (registered value), FSM SHALL enter VEND next cycle and assert o_vend.
REQ-017 In VEND, o_vend SHALL stay high until i_ack; on i_ack, credit <= credit-PRICE, o_vend drops next cycle, FSM goes to CHANGE if remainder >0 else IDLE.
REQ-018 In CHANGE, controller SHALL assert o_eject_50 if credit >= 2 else o_eject_25 (exactly one), held until i_ack.
REQ-019 On i_ack in CHANGE, credit SHALL decrement by 2 or 1 respectively, eject deasserts, FSM enters GAP.
REQ-020 GAP SHALL last exactly one cycle with no eject asserted, then return to CHANGE if credit >0 else IDLE.
REQ-021 i_cancel in IDLE with credit >0 SHALL send FSM to CHANGE (full refund); with credit 0 it SHALL be ignored.
REQ-022 Coin and i_cancel in same IDLE cycle: coin rule (REQ-015) applies first, refund covers the updated credit.
REQ-023 Any coin pulse while not IDLE SHALL be refused with one o_reject pulse; credit unchanged.
REQ-024 i_cancel outside IDLE and i_ack in IDLE/GAP SHALL be ignored.
REQ-025 Coin crossing PRICE and i_cancel same cycle: cancel SHALL win (refund, no vend).
REQ-026 Credit arithmetic SHALL never wrap; credit never exceeds MAX_CREDIT nor goes below 0.
REQ-027 Each change coin SHALL take at least 3 cycles (assert, ack, gap).

Reset
REQ-028 i_rst SHALL force IDLE, o_credit=0, o_vend=o_eject_50=o_eject_25=o_reject=o_busy=0 on the next edge, including mid-vend or mid-change; pending credit is lost.
REQ-029 i_rst SHALL override all other inputs in the same cycle.

Verification
REQ-030 Pulses 25,25,50 (PRICE=4) -> credit 1,2,4; o_vend rises next cycle; i_ack -> credit 0, IDLE, no eject.
REQ-031 Pulse 1 real then 50 (credit 6) -> vend; i_ack -> credit 2, o_eject_50 once, i_ack -> GAP -> IDLE, credit 0.
REQ-032 Credit 3 then i_cancel -> o_eject_50, ack, gap, o_eject_25, ack, gap, IDLE, credit 0.
REQ-033 Credit 7, 1-real pulse -> o_reject one cycle, credit 7; coin during VEND -> o_reject, credit unchanged.
REQ-034 Simultaneous 25+50 pulses at credit 0 -> credit 3; 25-pulse plus i_cancel same cycle at credit 1 -> refund 2 units (one 50 eject).
REQ-035 i_rst asserted while o_eject_50 held -> next cycle all outputs 0, credit 0, IDLE; subsequent i_ack ignored.
